// File: rtl/uart_sched_pkg.sv
// rtl/uart_sched_pkg.sv - state encodings and sizing shared by the UART memory scheduler
package uart_sched_pkg;

  localparam int unsigned DEF_ADDR_W = 5;
  localparam int unsigned DEPTH      = 1 << DEF_ADDR_W;

  typedef enum logic [1:0] {
    W_IDLE,
    W_WRITE,
    W_CLEAR
  } w_state_e;

  typedef enum logic [2:0] {
    R_IDLE,
    R_READ,
    R_LOAD,
    R_SEND,
    R_WAIT
  } r_state_e;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-request round-robin picker, last-grant state kept by the parent
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       valid
);

  // On a tie the channel that did not win last time is granted.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/uart_mem_scheduler.sv
// rtl/uart_mem_scheduler.sv - shares one byte memory between two UART receivers and the PC transmitter
module uart_mem_scheduler
  import uart_sched_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter logic [31:0] BASE_ADDR = 32'd0
) (
  input  logic              clock_50MHz,
  input  logic              reset,
  input  logic              rdy0,
  input  logic              rdy1,
  input  logic [7:0]        dout0,
  input  logic [7:0]        dout1,
  output logic              rdy_clr0,
  output logic              rdy_clr1,
  input  logic              tx_busy,
  input  logic              pc_busy,
  output logic              tx_enable,
  output logic [7:0]        tx_data,
  output logic              mem_we,
  output logic              mem_re,
  output logic [31:0]       mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

  w_state_e          w_state_q;
  r_state_e          r_state_q;
  logic [ADDR_W-1:0] wptr_q;
  logic [ADDR_W-1:0] rptr_q;
  logic [ADDR_W:0]   count_q;
  logic              last_q;
  logic              gnt_ch_q;
  logic              busy_seen_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic [31:0]       mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              rdy_clr0_q;
  logic              rdy_clr1_q;
  logic              tx_enable_q;
  logic [7:0]        tx_data_q;

  logic [1:0] pick_gnt;
  logic       pick_valid;
  logic       w_start;
  logic       r_go;
  logic       r_issue;
  logic       w_inc;
  logic       r_dec;

  rr_pick2 u_pick (
    .req   ({rdy1, rdy0}),
    .last  (last_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == '0);
  assign w_start = (w_state_q == W_IDLE) && !full && pick_valid;
  assign r_go    = !empty && !tx_busy && !pc_busy;
  assign w_inc   = (w_state_q == W_WRITE);
  assign r_dec   = (r_state_q == R_LOAD);

  // A read strobe for next cycle is suppressed whenever the write FSM is entering W_WRITE.
  assign r_issue = !w_start &&
                   (((r_state_q == R_IDLE) && r_go) ||
                    ((r_state_q == R_READ) && !mem_re_q));

  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) begin
      w_state_q   <= W_IDLE;
      wptr_q      <= '0;
      last_q      <= 1'b1;
      gnt_ch_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rdy_clr0_q  <= 1'b0;
      rdy_clr1_q  <= 1'b0;
    end else begin
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rdy_clr0_q  <= 1'b0;
      rdy_clr1_q  <= 1'b0;
      case (w_state_q)
        W_IDLE: begin
          if (w_start) begin
            gnt_ch_q    <= pick_gnt[1];
            mem_we_q    <= 1'b1;
            mem_wdata_q <= pick_gnt[0] ? dout0 : dout1;
            w_state_q   <= W_WRITE;
          end
        end
        W_WRITE: begin
          wptr_q     <= wptr_q + ADDR_W'(1);
          rdy_clr0_q <= !gnt_ch_q;
          rdy_clr1_q <= gnt_ch_q;
          w_state_q  <= W_CLEAR;
        end
        W_CLEAR: begin
          last_q    <= gnt_ch_q;
          w_state_q <= W_IDLE;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) begin
      r_state_q   <= R_IDLE;
      rptr_q      <= '0;
      mem_re_q    <= 1'b0;
      tx_enable_q <= 1'b0;
      tx_data_q   <= '0;
      busy_seen_q <= 1'b0;
    end else begin
      mem_re_q    <= r_issue;
      tx_enable_q <= 1'b0;
      case (r_state_q)
        R_IDLE: begin
          if (r_go) begin
            r_state_q <= R_READ;
          end
        end
        R_READ: begin
          if (mem_re_q) begin
            r_state_q <= R_LOAD;
          end
        end
        R_LOAD: begin
          tx_data_q   <= mem_rdata;
          rptr_q      <= rptr_q + ADDR_W'(1);
          tx_enable_q <= 1'b1;
          busy_seen_q <= 1'b0;
          r_state_q   <= R_SEND;
        end
        R_SEND: begin
          busy_seen_q <= tx_busy;
          r_state_q   <= R_WAIT;
        end
        R_WAIT: begin
          // The byte is finished only after busy has been seen high and then low again.
          if (tx_busy) begin
            busy_seen_q <= 1'b1;
          end else if (busy_seen_q) begin
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      mem_addr_q <= '0;
    end else begin
      case ({w_inc, r_dec})
        2'b10:   count_q <= count_q + (ADDR_W + 1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (w_start) begin
        mem_addr_q <= BASE_ADDR + 32'(wptr_q);
      end else if (r_issue) begin
        mem_addr_q <= BASE_ADDR + 32'(rptr_q);
      end else begin
        mem_addr_q <= '0;
      end
    end
  end

  assign rdy_clr0  = rdy_clr0_q;
  assign rdy_clr1  = rdy_clr1_q;
  assign tx_enable = tx_enable_q;
  assign tx_data   = tx_data_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign count     = count_q;

endmodule

// File: tb/tb_uart_mem_scheduler.sv
// tb/tb_uart_mem_scheduler.sv - directed self-checking bench for uart_mem_scheduler
module tb_uart_mem_scheduler;
  import uart_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        rdy0, rdy1;
  logic [7:0]  dout0, dout1;
  logic        rdy_clr0, rdy_clr1;
  logic        tx_busy, pc_busy;
  logic        tx_enable;
  logic [7:0]  tx_data;
  logic        mem_we, mem_re;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [5:0]  count;
  logic        full, empty;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [0:31];
  logic [7:0] txq [$];
  int         wa_q [$];
  logic [7:0] wd_q [$];
  int         clr0_n, clr1_n, en_n, busy_cnt, n_before;
  logic       hold_rdy;
  logic [7:0] tx_hold;
  logic       p_we, p_re, p_en, p_c0, p_c1, bad_strobe;

  uart_mem_scheduler dut (
    .clock_50MHz (clk),
    .reset       (reset),
    .rdy0        (rdy0),
    .rdy1        (rdy1),
    .dout0       (dout0),
    .dout1       (dout1),
    .rdy_clr0    (rdy_clr0),
    .rdy_clr1    (rdy_clr1),
    .tx_busy     (tx_busy),
    .pc_busy     (pc_busy),
    .tx_enable   (tx_enable),
    .tx_data     (tx_data),
    .mem_we      (mem_we),
    .mem_re      (mem_re),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .count       (count),
    .full        (full),
    .empty       (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, check cycle invariants and run the UART, memory and TX models.
  task automatic tick();
    @(negedge clk);
    bad_strobe = (mem_we & mem_re) | (mem_we & p_we) | (mem_re & p_re) | (tx_enable & p_en) |
                 (rdy_clr0 & p_c0) | (rdy_clr1 & p_c1) | (!mem_we & !mem_re & (mem_addr != 32'd0));
    check("strobe", 32'(bad_strobe), 32'd0);
    if (tx_busy) check("tx_stable", 32'(tx_data), 32'(tx_hold));
    p_we = mem_we; p_re = mem_re; p_en = tx_enable; p_c0 = rdy_clr0; p_c1 = rdy_clr1;
    if (mem_we) begin
      mem[mem_addr[4:0]] = mem_wdata;
      wa_q.push_back(int'(mem_addr));
      wd_q.push_back(mem_wdata);
    end
    if (mem_re) mem_rdata = mem[mem_addr[4:0]];
    if (rdy_clr0) begin clr0_n++; if (!hold_rdy) rdy0 = 1'b0; end
    if (rdy_clr1) begin clr1_n++; if (!hold_rdy) rdy1 = 1'b0; end
    if (tx_enable) begin
      txq.push_back(tx_data);
      en_n++;
      busy_cnt = 10;
      tx_hold = tx_data;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = (busy_cnt != 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0; hold_rdy = 1'b0;
    busy_cnt = 0; tx_busy = 1'b0; pc_busy = 1'b1;
    tick(); tick();
    reset = 1'b0;
    wa_q.delete(); wd_q.delete(); txq.delete();
    clr0_n = 0; clr1_n = 0; en_n = 0;
  endtask

  task automatic send_byte0(input logic [7:0] b, input string tag);
    dout0 = b; rdy0 = 1'b1;
    for (int k = 0; k < 10 && rdy0; k++) tick();
    check(tag, 32'(rdy0), 32'd0);
  endtask

  initial begin
    reset = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0; dout0 = '0; dout1 = '0;
    tx_busy = 1'b0; pc_busy = 1'b0; mem_rdata = '0; hold_rdy = 1'b0;
    busy_cnt = 0; tx_hold = '0; clr0_n = 0; clr1_n = 0; en_n = 0;
    p_we = 0; p_re = 0; p_en = 0; p_c0 = 0; p_c1 = 0;
    tick(); tick();
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_re", 32'(mem_re), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_txen", 32'(tx_enable), 32'd0);
    check("rst_txdata", 32'(tx_data), 32'd0);
    check("rst_clr", 32'({rdy_clr1, rdy_clr0}), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    reset = 1'b0;

    // Single byte on channel 0 with the PC free: write, clear, then read and transmit.
    rdy0 = 1'b1; dout0 = 8'hA5;
    tick();
    check("s1_we", 32'(mem_we), 32'd1);
    check("s1_waddr", mem_addr, 32'd0);
    check("s1_wdata", 32'(mem_wdata), 32'hA5);
    tick();
    check("s1_clr0", 32'(rdy_clr0), 32'd1);
    check("s1_count", 32'(count), 32'd1);
    check("s1_empty", 32'(empty), 32'd0);
    tick();
    check("s1_clr0_off", 32'(rdy_clr0), 32'd0);
    check("s1_re", 32'(mem_re), 32'd1);
    check("s1_raddr", mem_addr, 32'd0);
    tick(); tick();
    check("s1_txen", 32'(tx_enable), 32'd1);
    check("s1_txdata", 32'(tx_data), 32'hA5);
    tick();
    check("s1_txen_off", 32'(tx_enable), 32'd0);
    repeat (20) tick();
    check("s1_clr_n", 32'(clr0_n), 32'd1);
    check("s1_en_n", 32'(en_n), 32'd1);
    check("s1_count_end", 32'(count), 32'd0);
    check("s1_empty_end", 32'(empty), 32'd1);

    // Both channels held ready: grants alternate starting with channel 0.
    do_reset();
    hold_rdy = 1'b1; rdy0 = 1'b1; rdy1 = 1'b1; dout0 = 8'h11; dout1 = 8'h22;
    repeat (12) tick();
    rdy0 = 1'b0; rdy1 = 1'b0; hold_rdy = 1'b0;
    check("rr_nwrites", 32'(wa_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wa_q.size()) begin
        check("rr_addr", 32'(wa_q[i]), 32'(i));
        check("rr_data", 32'(wd_q[i]), (i % 2 == 0) ? 32'h11 : 32'h22);
      end
    end
    check("rr_clr0", 32'(clr0_n), 32'd2);
    check("rr_clr1", 32'(clr1_n), 32'd2);
    check("rr_count", 32'(count), 32'd4);

    // Fill to full with the PC busy, hold a 33rd byte pending, then drain.
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_byte0(8'(8'h80 + i), "fill_clr");
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd32);
    dout0 = 8'hEE; rdy0 = 1'b1;
    repeat (10) tick();
    check("full_noclr", 32'(clr0_n), 32'd32);
    check("full_nowrite", 32'(wa_q.size()), 32'd32);
    check("full_pending", 32'(rdy0), 32'd1);
    pc_busy = 1'b0;
    for (int k = 0; k < 1500 && txq.size() < 33; k++) tick();
    repeat (20) tick();
    check("drain_n", 32'(txq.size()), 32'd33);
    for (int i = 0; i < 33; i++) begin
      if (i < txq.size()) check("drain_byte", 32'(txq[i]), (i < 32) ? 32'(8'h80 + i) : 32'hEE);
    end
    check("wrap_nwrites", 32'(wa_q.size()), 32'd33);
    if (wa_q.size() == 33) begin
      check("wrap_addr", 32'(wa_q[32]), 32'd0);
      check("wrap_data", 32'(wd_q[32]), 32'hEE);
    end
    check("drain_en_n", 32'(en_n), 32'd33);
    check("drain_count", 32'(count), 32'd0);
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_full", 32'(full), 32'd0);
    check("drain_clr0", 32'(clr0_n), 32'd33);

    // Read start collides with a write: the read strobe slips by one cycle.
    do_reset();
    send_byte0(8'h5A, "col_clr");
    tick();
    pc_busy = 1'b0; rdy1 = 1'b1; dout1 = 8'h77;
    tick();
    check("col_we", 32'(mem_we), 32'd1);
    check("col_re_held", 32'(mem_re), 32'd0);
    check("col_waddr", mem_addr, 32'd1);
    tick();
    check("col_re", 32'(mem_re), 32'd1);
    check("col_we_off", 32'(mem_we), 32'd0);
    check("col_raddr", mem_addr, 32'd0);
    tick(); tick();
    check("col_txen", 32'(tx_enable), 32'd1);
    check("col_txdata", 32'(tx_data), 32'h5A);
    for (int k = 0; k < 100 && txq.size() < 2; k++) tick();
    repeat (20) tick();
    check("col_ntx", 32'(txq.size()), 32'd2);
    if (txq.size() == 2) check("col_second", 32'(txq[1]), 32'h77);
    check("col_count", 32'(count), 32'd0);

    // Reset while waiting on the transmitter with three bytes still buffered.
    do_reset();
    for (int i = 0; i < 4; i++) send_byte0(8'(8'hC0 + i), "rw_clr");
    check("rw_count4", 32'(count), 32'd4);
    pc_busy = 1'b0;
    for (int k = 0; k < 20 && en_n == 0; k++) tick();
    check("rw_sent", 32'(en_n), 32'd1);
    tick(); tick();
    check("rw_count3", 32'(count), 32'd3);
    reset = 1'b1; busy_cnt = 0; tx_busy = 1'b0;
    tick();
    check("rw_we", 32'(mem_we), 32'd0);
    check("rw_re", 32'(mem_re), 32'd0);
    check("rw_addr", mem_addr, 32'd0);
    check("rw_wdata", 32'(mem_wdata), 32'd0);
    check("rw_txen", 32'(tx_enable), 32'd0);
    check("rw_txdata", 32'(tx_data), 32'd0);
    check("rw_clr", 32'({rdy_clr1, rdy_clr0}), 32'd0);
    check("rw_count", 32'(count), 32'd0);
    check("rw_full", 32'(full), 32'd0);
    check("rw_empty", 32'(empty), 32'd1);
    reset = 1'b0;
    n_before = en_n;
    repeat (40) tick();
    check("rw_no_tx", 32'(en_n), 32'(n_before));
    check("rw_count_end", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_mem_scheduler.md
# uart_mem_scheduler

Scheduler that shares the single-port byte memory between the two UART receivers and the PC-side UART transmitter. Round-robin arbitration grants one RX channel per write. The granted byte is written into a circular buffer region of the memory and the channel's `rdy` is cleared. Buffered bytes are read back in FIFO order and handed to the UART transmitter whenever it and the PC are not busy. The block sits between the two `uart` instances and the memory, and replaces the fixed-address write/read wiring at top level.

## Interface
Parameters:
- `ADDR_W`, 5: buffer index width; buffer depth = 2^ADDR_W bytes.
- `BASE_ADDR`, 32'd0: memory address of buffer entry 0.

Ports:
- `clock_50MHz` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high.
- `rdy0`, `rdy1` in 1: RX byte-ready from UART 0 / 1.
- `dout0`, `dout1` in 8: RX data from UART 0 / 1.
- `rdy_clr0`, `rdy_clr1` out 1: one-cycle clear pulse to UART 0 / 1.
- `tx_busy` in 1: transmitter busy.
- `pc_busy` in 1: PC not accepting; blocks new transmissions.
- `tx_enable` out 1: one-cycle start pulse to transmitter.
- `tx_data` out 8: byte to transmit, held stable from `tx_enable` until `tx_busy` falls.
- `mem_we` out 1: memory write strobe.
- `mem_re` out 1: memory read strobe.
- `mem_addr` out 32: memory address.
- `mem_wdata` out 8: memory write data.
- `mem_rdata` in 8: memory read data, valid the cycle after `mem_re`.
- `count` out ADDR_W+1: bytes buffered.
- `full` out 1: `count == 2^ADDR_W`.
- `empty` out 1: `count == 0`.

## Operation
Write FSM, states W_IDLE, W_WRITE, W_CLEAR:
- **W_IDLE**: if `!full` and any `rdy`, grant a channel.
  - Both ready: grant the channel not granted last.
  - Only one ready: grant that channel.
  - Latch the grant and its byte, then go to W_WRITE.
  - If `full`: grant nothing and send no clear; the byte stays pending in the UART.
- **W_WRITE**:
  - Drive `mem_we=1`, `mem_addr=BASE_ADDR+wptr`, `mem_wdata`=latched byte.
  - `wptr` increments modulo 2^ADDR_W; `count` increments.
  - Go to W_CLEAR.
- **W_CLEAR**: pulse `rdy_clr` of the granted channel, update the last-grant bit, return to W_IDLE.

Read FSM, states R_IDLE, R_READ, R_LOAD, R_SEND, R_WAIT:
- **R_IDLE**: go to R_READ when `!empty`, `!tx_busy` and `!pc_busy`.
- **R_READ**: drive `mem_re=1`, `mem_addr=BASE_ADDR+rptr`, except in a cycle where the write FSM is in W_WRITE.
  - Write has priority. The read retries next cycle and the state is held.
  - Advance to R_LOAD only on a cycle the read was issued.
- **R_LOAD**: capture `mem_rdata` into `tx_data`; `rptr` increments modulo 2^ADDR_W; `count` decrements.
- **R_SEND**: `tx_enable=1` for one cycle.
- **R_WAIT**: wait for `tx_busy` to rise and then fall, then return to R_IDLE.

Rules and boundary conditions:
- Increment and decrement of `count` in the same cycle leave it unchanged.
- `pc_busy` asserted after R_READ does not abort the byte in flight.
- `mem_addr` is 0 when neither strobe is active.
- The pointers wrap silently; `count` alone distinguishes full from empty.

## Timing
- Reset: every output is 0, except `empty`, which is 1.
  - Both FSMs go to idle; `wptr`, `rptr` and `count` are 0; the last-grant bit is 1, so channel 0 wins the first tie.
  - A reset mid-sequence drops any partially handled byte; no clear is issued for it.
- RX latency: `rdy` seen in W_IDLE → `mem_we` next cycle → `rdy_clr` the cycle after. This is 3 cycles per byte.
- TX latency from `empty` falling, both busy inputs low: `mem_re` at +1, `tx_data` valid at +3, `tx_enable` at +3. Each write collision adds 1 cycle.
- Strobes `mem_we`, `mem_re`, `tx_enable` and `rdy_clr*` are registered, never two cycles long, and `mem_we` and `mem_re` are never high together.

## Structure
- Package `uart_sched_pkg` holds:
  - the write-state and read-state encodings;
  - localparam `DEPTH = 1 << ADDR_W`.
- Sub-module `rr_pick2`: two-request round-robin picker.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `gnt[1:0]`, `valid`.
  - Purely combinational; the last-grant register lives in the parent.

## Test plan
- After reset, `rdy0=1`, `dout0=8'hA5`: `mem_we` at `mem_addr=0` with data A5; `rdy_clr0` pulses once; `count=1`.
- `rdy0` and `rdy1` both high continuously, data 11 and 22: writes alternate 11, 22, 11, 22 at addresses 0–3, starting with channel 0.
- With `pc_busy=1`, fill 32 bytes: `full=1` and no `rdy_clr` occurs while the 33rd `rdy` is pending. Releasing `pc_busy` drains the bytes in order; `wptr` wraps and the 33rd byte is written to address 0.
- Read in R_READ colliding with W_WRITE: `mem_re` is delayed exactly 1 cycle, strobes never overlap, and the transmitted byte is the oldest entry.
- `tx_busy` model: 10 cycles high after each `tx_enable`. Exactly one `tx_enable` per byte, `tx_data` stable throughout busy, `count` returns to 0 and `empty=1`.
- Assert `reset` while in R_WAIT with `count=3`: all outputs and counters are zero next cycle, `empty=1`, and no further `tx_enable` occurs.
